// File: rtl/button_counter.sv
// button_counter: two asynchronous push buttons are synchronized, debounced
// against a shared prescaler tick and turned into one-cycle press pulses
// that step an up/down counter shown on the LED bank.
//
// Handshake: there is no valid/ready pair here. up_pulse/down_pulse are
// registered, one cycle wide, and each marks one accepted press. led
// reflects that pulse in the following cycle.
module button_counter #(
    parameter int N      = 8000,
    parameter int STABLE = 10,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_up,
    input  logic         btn_down,
    output logic [W-1:0] led,
    output logic         up_pulse,
    output logic         down_pulse
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    // Bit/index 0 is the up button, 1 is the down button throughout.
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    db_state_e     state_q [2];
    db_state_e     state_d [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [1:0]    pulse_q, pulse_d;
    logic [W-1:0]  led_q, led_d;

    // Two-flop synchronizer inputs; only the second stage is used downstream.
    always_comb begin
        sync1_d = {btn_down, btn_up};
        sync2_d = sync1_q;
    end

    // Free-running prescaler shared by both debouncers; tick on the last count.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Debounce FSMs: a new level must survive STABLE ticks; any level change
    // during a wait drops back to the settled state so cnt never accumulates.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            pulse_d[b] = 1'b0;
            case (state_q[b])
                IDLE: begin
                    if (sync2_q[b]) begin
                        state_d[b] = PRESS_WAIT;
                        cnt_d[b]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[b]) begin
                        state_d[b] = IDLE;
                        cnt_d[b]   = '0;
                    end else if (tick) begin
                        if (cnt_q[b] == CNT_LAST) begin
                            state_d[b] = PRESSED;
                            cnt_d[b]   = '0;
                            pulse_d[b] = 1'b1;
                        end else begin
                            cnt_d[b] = cnt_q[b] + CW'(1);
                        end
                    end
                end
                PRESSED: begin
                    if (!sync2_q[b]) begin
                        state_d[b] = RELEASE_WAIT;
                        cnt_d[b]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high resumes the held press without a pulse.
                    if (sync2_q[b]) begin
                        state_d[b] = PRESSED;
                        cnt_d[b]   = '0;
                    end else if (tick) begin
                        if (cnt_q[b] == CNT_LAST) begin
                            state_d[b] = IDLE;
                            cnt_d[b]   = '0;
                        end else begin
                            cnt_d[b] = cnt_q[b] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[b] = IDLE;
                    cnt_d[b]   = '0;
                end
            endcase
        end
    end

    // Up/down counter reacting to the registered pulses; simultaneous presses cancel.
    always_comb begin
        led_d = led_q;
        case (pulse_q)
            2'b01:   led_d = led_q + W'(1);
            2'b10:   led_d = led_q - W'(1);
            default: led_d = led_q;
        endcase
    end

    // All state registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            pulse_q <= '0;
            led_q   <= '0;
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            pulse_q <= pulse_d;
            led_q   <= led_d;
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
        end
    end

    assign led        = led_q;
    assign up_pulse   = pulse_q[0];
    assign down_pulse = pulse_q[1];

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter with N=4, STABLE=3, W=8. A reference model turns
// the driven button levels into expected press events (edge index + kind)
// pushed on exp_q; a monitor pops them when the DUT pulses and also tracks
// the expected LED value every cycle.
module tb_button_counter;

    localparam int N      = 4;
    localparam int STABLE = 3;
    localparam int W      = 8;
    localparam int EW     = 34;  // {edge[31:0], down, up}

    logic         clk;
    logic         rst;
    logic         btn_up;
    logic         btn_down;
    logic [W-1:0] led;
    logic         up_pulse;
    logic         down_pulse;

    button_counter #(.N(N), .STABLE(STABLE), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .led        (led),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            m_edge = 0;
    logic [W-1:0]  m_led = '0;
    logic          chk_en = 1'b0;
    int            up_seen = 0;
    int            down_seen = 0;
    int            both_seen = 0;
    int            last_up_edge = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, m_edge);
        end
    endtask

    // ---------------- reference model ----------------
    // A new level of a button is accepted once the synchronized level has
    // differed from the accepted one for STABLE prescaler ticks, not counting
    // the edge where the difference first appears. Ticks fall on every N-th
    // edge after reset. Accepting a high level yields a press event.
    initial begin : model
        logic [1:0] m_d1, m_d2, s, m_acc, m_pend, m_pul;
        int         m_ticks [2];
        int         m_since_rst;
        logic       tick;
        m_d1 = '0; m_d2 = '0; m_acc = '0; m_pend = '0; m_pul = '0;
        m_ticks[0] = 0; m_ticks[1] = 0; m_since_rst = 0;
        forever begin
            @(posedge clk);
            m_edge++;
            if (rst) begin
                m_d1 = '0; m_d2 = '0; m_acc = '0; m_pend = '0; m_pul = '0;
                m_ticks[0] = 0; m_ticks[1] = 0; m_since_rst = 0;
                m_led = '0;
            end else begin
                if (m_pul == 2'b01) m_led = m_led + 1'b1;
                if (m_pul == 2'b10) m_led = m_led - 1'b1;
                m_since_rst++;
                tick = ((m_since_rst % N) == 0);
                s    = m_d2;
                m_d2 = m_d1;
                m_d1 = {btn_down, btn_up};
                m_pul = '0;
                for (int b = 0; b < 2; b++) begin
                    if (s[b] == m_acc[b]) begin
                        m_pend[b] = 1'b0;
                    end else if (!m_pend[b]) begin
                        m_pend[b]  = 1'b1;
                        m_ticks[b] = 0;
                    end else if (tick) begin
                        m_ticks[b]++;
                        if (m_ticks[b] == STABLE) begin
                            m_acc[b]  = s[b];
                            m_pend[b] = 1'b0;
                            if (s[b]) m_pul[b] = 1'b1;
                        end
                    end
                end
                if (m_pul != 2'b00) exp_q.push_back({32'(m_edge), m_pul});
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        logic [31:0]   front_edge;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("led", 32'(led), 32'(m_led));
                if (up_pulse || down_pulse) begin
                    if (up_pulse) begin
                        up_seen++;
                        last_up_edge = m_edge;
                    end
                    if (down_pulse) down_seen++;
                    if (up_pulse && down_pulse) both_seen++;
                    if (exp_q.size() == 0) begin
                        chk("spurious_pulse", 32'({down_pulse, up_pulse}), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_edge", 32'(m_edge), e[33:2]);
                        chk("pulse_kind", 32'({down_pulse, up_pulse}), 32'(e[1:0]));
                    end
                end else if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    front_edge = e[33:2];
                    if (front_edge <= 32'(m_edge)) begin
                        e = exp_q.pop_front();
                        chk("missed_pulse", 32'd0, 32'(e[1:0]));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; levels hold for the given number of cycles.
    task automatic drive(input logic up, input logic dn, input int cycles);
        btn_up   = up;
        btn_down = dn;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input logic up, input logic dn);
        drive(up, dn, 40);
        drive(1'b0, 1'b0, 30);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int base_up, base_dn, base_both, r, lat, rst_edge;
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_up_pulse", 32'(up_pulse), 32'd0);
        chk("reset_down_pulse", 32'(down_pulse), 32'd0);
        @(negedge clk);

        // 1: long hold gives exactly one pulse within the latency window
        base_up = up_seen;
        r = m_edge + 1;
        drive(1'b1, 1'b0, 40);
        #1;
        chk("t1_one_pulse", 32'(up_seen - base_up), 32'd1);
        lat = last_up_edge - r + 1;
        chk("t1_latency_window", 32'(lat >= 12 && lat <= 24), 32'd1);
        chk("t1_led_held", 32'(led), 32'd1);
        drive(1'b0, 1'b0, 30);
        #1;
        chk("t1_led_released", 32'(led), 32'd1);
        chk("t1_no_release_pulse", 32'(up_seen - base_up), 32'd1);

        // 2: short glitch rejected, then bounce and settle
        reset_dut();
        base_up = up_seen;
        drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 20);
        #1;
        chk("t2_glitch_no_pulse", 32'(up_seen - base_up), 32'd0);
        chk("t2_glitch_led", 32'(led), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, $urandom_range(1, 3));
            drive(1'b0, 1'b0, $urandom_range(1, 3));
        end
        drive(1'b1, 1'b0, 30);
        drive(1'b0, 1'b0, 30);
        #1;
        chk("t2_settle_one_pulse", 32'(up_seen - base_up), 32'd1);
        chk("t2_settle_led", 32'(led), 32'd1);

        // 3: wrap in both directions
        reset_dut();
        base_dn = down_seen;
        press(1'b0, 1'b1);
        #1;
        chk("t3_down_wrap", 32'(led), 32'd255);
        chk("t3_down_count", 32'(down_seen - base_dn), 32'd1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        #1;
        chk("t3_up_wrap", 32'(led), 32'd1);

        // 4: simultaneous presses cancel on the counter
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        #1;
        chk("t4_led_before", 32'(led), 32'd5);
        base_both = both_seen;
        press(1'b1, 1'b1);
        #1;
        chk("t4_both_same_cycle", 32'(both_seen - base_both), 32'd1);
        chk("t4_led_unchanged", 32'(led), 32'd5);

        // 5: reset mid-hold requalifies the still-held button
        reset_dut();
        drive(1'b1, 1'b0, 40);
        #1;
        chk("t5_led_before_rst", 32'(led), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rst_edge = m_edge;
        #1;
        chk("t5_rst_led", 32'(led), 32'd0);
        chk("t5_rst_pulses", 32'({down_pulse, up_pulse}), 32'd0);
        base_up = up_seen;
        @(negedge clk);
        drive(1'b1, 1'b0, 40);
        #1;
        chk("t5_requalified", 32'(up_seen - base_up), 32'd1);
        chk("t5_requal_latency", 32'((last_up_edge - rst_edge) >= 12), 32'd1);
        chk("t5_led_after", 32'(led), 32'd1);
        drive(1'b0, 1'b0, 30);

        // 6: release bounce gives no extra pulse
        base_up = up_seen;
        drive(1'b1, 1'b0, 40);
        drive(1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 30);
        #1;
        chk("t6_release_bounce", 32'(up_seen - base_up), 32'd1);
        chk("t6_led", 32'(led), 32'd2);
        press(1'b1, 1'b0);
        #1;
        chk("t6_next_press", 32'(led), 32'd3);

        // random phase: both buttons, random levels and hold times
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 30));
        end
        drive(1'b0, 1'b0, 40);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
